pagerank_mem_arbiter: RTL and testbench
=======================================

# pagerank_mem_arbiter

Shares one memory request/response port pair among `nreqs` PageRank requesters, such as the R-vector loader and the G-matrix column streamer under the scheduler. It picks one valid requester per cycle and forwards its memory request unmodified. It records the granted requester index in an in-order tag FIFO and routes each memory response back to the requester at the FIFO head. Memory responses return in request order; the block relies on that ordering.

## Interface
- `nreqs`, 2: number of upstream requesters, 2..4.
- `ntags`, 4: tag FIFO depth (max outstanding requests), power of two, 2..16.
- `clk` input 1: clock.
- `reset` input 1: asynchronous, active-high reset.
- `req_msg` input nreqs*`VC_MEM_REQ_MSG_NBITS(8,32,32)` (77 each): upstream requests; requester i occupies slice i.
- `req_val` input nreqs: per-requester request valid.
- `req_rdy` output nreqs: per-requester request ready.
- `resp_msg` output nreqs*`VC_MEM_RESP_MSG_NBITS(8,32)` (47 each): upstream responses; every slice carries `mem_resp_msg`.
- `resp_val` output nreqs: per-requester response valid.
- `resp_rdy` input nreqs: per-requester response ready.
- `mem_req_msg` output 77: downstream request.
- `mem_req_val` output 1: downstream request valid.
- `mem_req_rdy` input 1: downstream request ready.
- `mem_resp_msg` input 47: downstream response.
- `mem_resp_val` input 1: downstream response valid.
- `mem_resp_rdy` output 1: downstream response ready.

## Operation
- All message fields pass through unmodified, including type, opaque, addr, len and data. No width conversion.
- Grant:
  - Exactly one requester `g` is chosen among those with `req_val` high, per the priority in Configuration.
  - `mem_req_msg` = slice `g`.
  - `mem_req_val` = any `req_val` && !full.
  - `req_rdy[i]` = (i==g) && `mem_req_rdy` && !full. All other `req_rdy` bits are 0.
- Request handshake (`mem_req_val` && `mem_req_rdy`): push `g` into the tag FIFO.
- Response routing:
  - `resp_val[i]` = `mem_resp_val` && !empty && (head==i).
  - `mem_resp_rdy` = !empty && `resp_rdy[head]`.
  - Response handshake pops the FIFO.
- Empty FIFO: `mem_resp_rdy`=0 and all `resp_val`=0. A stray response is held, never dropped or misrouted.
- Full FIFO:
  - `mem_req_val`=0 and all `req_rdy`=0, even when a pop occurs in the same cycle. This is a registered-only full, which avoids a combinational resp→req path.
  - Simultaneous push and pop when not full: the count is unchanged and head/tail both advance.
- Occupancy count is `$clog2(ntags)+1` bits, range 0..ntags. Read/write pointers wrap modulo ntags.
- Reset mid-operation: the FIFO empties, the priority pointer returns to 0, and responses to pre-reset requests are held per the empty rule.

## Timing
- Zero-cycle latency both directions:
  - `req_val` → `mem_req_val`.
  - `mem_resp_val` → `resp_val`.
- Throughput: one request and one response per cycle.
- State registers:
  - Tag array.
  - Read/write pointers.
  - Count.
  - Round-robin pointer `rr_ptr`.
- All state updates on posedge `clk`; all state is cleared asynchronously by `reset`.
- Reset output values: `mem_req_val`=0, `mem_resp_rdy`=0, `resp_val`=0, `req_rdy`=0 (these are combinational, so they hold 0 while reset is asserted and inputs idle).
- Valid must not depend on ready on any port.

## Configuration
- `PAGERANK_MEM_ARB_RR_EN` defined:
  - Round-robin priority starting at `rr_ptr`, searching upward with wrap.
  - On each request handshake, `rr_ptr` ← (g+1) mod nreqs.
  - `rr_ptr` resets to 0.
- Undefined:
  - Fixed priority; the lowest index wins.
  - `rr_ptr` is not instantiated.

## Structure
- Shared include `pageRank-msgs.v` gains:
  - `PAGERANK_MEM_REQ_NBITS` (77).
  - `PAGERANK_MEM_RESP_NBITS` (47).
  - `PAGERANK_ARB_MAX_REQS` (4).
- One sub-module, `pagerank_tag_fifo`, with parameters `nbits`=$clog2(nreqs) and `ntags`:
  - Ports: push/pop strobes, `full`, `empty`, `head`.
  - Async active-high reset.
- Arbitration and muxing stay in the top module.

## Test plan
- Single requester: req0 read addr 0x100 with memory latency 1 → `mem_req_msg` equals req0 bits; response data 0xDEADBEEF appears only on `resp_val[0]`.
- Both requesters valid every cycle, RR_EN defined → grants alternate 0,1,0,1; undefined → req0 granted every cycle and req1 is starved.
- Memory stalls responses, ntags=4 → exactly 4 requests accepted, then `req_rdy`=0. The first response frees a slot one cycle later.
- Interleaved requests 0,1,1,0 with addrs 0x0/0x4/0x8/0xC, in-order responses → data delivered to requesters 0,1,1,0 in order; `resp_rdy[1]` low stalls `mem_resp_rdy`.
- Response presented with the FIFO empty → `mem_resp_rdy`=0 and all `resp_val`=0 for all cycles held.
- Assert `reset` asynchronously with 3 outstanding requests → next cycle count=0, outputs idle, `rr_ptr`=0; a new req1 is granted immediately.

Source files
------------

// File: rtl/pagerank_mem_arbiter_pkg.sv
// Shared widths and helpers for the PageRank memory arbiter.
package pagerank_mem_arbiter_pkg;

    localparam int PAGERANK_MEM_REQ_NBITS  = 77;
    localparam int PAGERANK_MEM_RESP_NBITS = 47;
    localparam int PAGERANK_ARB_MAX_REQS   = 4;

    function automatic int idx_bits(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pagerank_tag_fifo.sv
// In-order FIFO of granted requester indices.
// It steers each in-order memory response back to its requester.
module pagerank_tag_fifo #(
    parameter int nbits = 1,
    parameter int ntags = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [nbits-1:0] push_tag,
    output logic             full,
    output logic             empty,
    output logic [nbits-1:0] head
);

    localparam int pw = (ntags < 2) ? 1 : $clog2(ntags);
    localparam logic [pw:0] depth = (pw + 1)'(ntags);

    logic [nbits-1:0] tags [ntags];
    logic [pw-1:0]    rd_ptr;
    logic [pw-1:0]    wr_ptr;
    logic [pw:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == depth);
    assign empty   = (count == '0);
    assign head    = tags[rd_ptr];

    // ntags is a power of two, so the pointers wrap by overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ntags; i++) begin
                tags[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                tags[wr_ptr] <= push_tag;
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/pagerank_mem_arbiter.sv
// Shares one memory port among nreqs requesters; responses routed in order.
// Define PAGERANK_MEM_ARB_RR_EN for round-robin, else fixed priority.
module pagerank_mem_arbiter
    import pagerank_mem_arbiter_pkg::*;
#(
    parameter int nreqs = 2,
    parameter int ntags = 4
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [nreqs*PAGERANK_MEM_REQ_NBITS-1:0]    req_msg,
    input  logic [nreqs-1:0]                           req_val,
    output logic [nreqs-1:0]                           req_rdy,
    output logic [nreqs*PAGERANK_MEM_RESP_NBITS-1:0]   resp_msg,
    output logic [nreqs-1:0]                           resp_val,
    input  logic [nreqs-1:0]                           resp_rdy,
    output logic [PAGERANK_MEM_REQ_NBITS-1:0]          mem_req_msg,
    output logic                                       mem_req_val,
    input  logic                                       mem_req_rdy,
    input  logic [PAGERANK_MEM_RESP_NBITS-1:0]         mem_resp_msg,
    input  logic                                       mem_resp_val,
    output logic                                       mem_resp_rdy
);

    localparam int nbits = idx_bits(nreqs);
    typedef logic [nbits-1:0] idx_t;

    idx_t grant;
    idx_t base;
    idx_t head;
    logic any_val;
    logic found;
    logic full;
    logic empty;
    logic push;
    logic pop;

`ifdef PAGERANK_MEM_ARB_RR_EN
    idx_t rr_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (push) begin
            rr_ptr <= (int'(grant) == nreqs - 1) ? '0 : grant + 1'b1;
        end
    end

    assign base = rr_ptr;
`else
    assign base = '0;
`endif

    // Search upward from base with wrap; fixed priority uses base 0
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < nreqs; k++) begin
            int idx;
            idx = int'(base) + k;
            if (idx >= nreqs) begin
                idx = idx - nreqs;
            end
            if (!found && req_val[idx]) begin
                grant = idx_t'(idx);
                found = 1'b1;
            end
        end
    end

    assign any_val     = |req_val;
    assign mem_req_msg = req_msg[int'(grant)*PAGERANK_MEM_REQ_NBITS +: PAGERANK_MEM_REQ_NBITS];
    assign mem_req_val = any_val && !full;
    assign push        = mem_req_val && mem_req_rdy;

    always_comb begin
        req_rdy = '0;
        if (any_val && mem_req_rdy && !full) begin
            req_rdy[grant] = 1'b1;
        end
    end

    // Full is registered only, so a same-cycle pop never reopens requests
    assign resp_msg     = {nreqs{mem_resp_msg}};
    assign mem_resp_rdy = !empty && resp_rdy[head];
    assign pop          = mem_resp_val && mem_resp_rdy;

    always_comb begin
        resp_val = '0;
        if (mem_resp_val && !empty) begin
            resp_val[head] = 1'b1;
        end
    end

    pagerank_tag_fifo #(
        .nbits (nbits),
        .ntags (ntags)
    ) tag_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .push_tag (grant),
        .full     (full),
        .empty    (empty),
        .head     (head)
    );

endmodule

// File: tb/tb_pagerank_mem_arbiter.sv
// Bench for pagerank_mem_arbiter: directed literals plus random traffic
// checked each cycle against a queue-based reference model.
module tb_pagerank_mem_arbiter;

    localparam int NR = 2;
    localparam int NT = 4;
    localparam int QW = 77;
    localparam int SW = 47;

    logic              clk;
    logic              reset;
    logic [NR*QW-1:0]  req_msg;
    logic [NR-1:0]     req_val;
    logic [NR-1:0]     req_rdy;
    logic [NR*SW-1:0]  resp_msg;
    logic [NR-1:0]     resp_val;
    logic [NR-1:0]     resp_rdy;
    logic [QW-1:0]     mem_req_msg;
    logic              mem_req_val;
    logic              mem_req_rdy;
    logic [SW-1:0]     mem_resp_msg;
    logic              mem_resp_val;
    logic              mem_resp_rdy;

    pagerank_mem_arbiter #(
        .nreqs (NR),
        .ntags (NT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_msg      (req_msg),
        .req_val      (req_val),
        .req_rdy      (req_rdy),
        .resp_msg     (resp_msg),
        .resp_val     (resp_val),
        .resp_rdy     (resp_rdy),
        .mem_req_msg  (mem_req_msg),
        .mem_req_val  (mem_req_val),
        .mem_req_rdy  (mem_req_rdy),
        .mem_resp_msg (mem_resp_msg),
        .mem_resp_val (mem_resp_val),
        .mem_resp_rdy (mem_resp_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    // Reference model: outstanding requester ids in issue order
    int q[$];
    int rr;
    bit m_push;
    bit m_pop;
    logic [SW-1:0] memq[$];

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic int pick();
`ifdef PAGERANK_MEM_ARB_RR_EN
        for (int k = 0; k < NR; k++) begin
            if (req_val[(rr + k) % NR]) return (rr + k) % NR;
        end
`else
        for (int k = 0; k < NR; k++) begin
            if (req_val[k]) return k;
        end
`endif
        return 0;
    endfunction

    function automatic logic [QW-1:0] rand_req();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[QW-1:0];
    endfunction

    function automatic logic [SW-1:0] rand_resp();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[SW-1:0];
    endfunction

    function automatic logic [QW-1:0] mk_req(input logic [31:0] addr, input logic [7:0] opq);
        return {3'd0, opq, addr, 2'd0, 32'd0};
    endfunction

    task automatic model_reset();
        q.delete();
        rr = 0;
    endtask

    task automatic idle();
        req_val      = '0;
        req_msg      = '0;
        resp_rdy     = '1;
        mem_req_rdy  = 1'b1;
        mem_resp_val = 1'b0;
        mem_resp_msg = '0;
    endtask

    // Compare every output with the model, then advance the model
    task automatic check_cycle();
        bit any;
        bit full;
        bit empty;
        bit e_mval;
        bit e_mrr;
        int g;
        int head;
        logic [NR-1:0] e_rdy;
        logic [NR-1:0] e_rv;
        #1;
        any   = (req_val != '0);
        full  = (q.size() == NT);
        empty = (q.size() == 0);
        g     = pick();
        head  = empty ? 0 : q[0];
        e_mval = any && !full;
        e_rdy = '0;
        if (any && !full && mem_req_rdy) e_rdy[g] = 1'b1;
        e_rv = '0;
        if (mem_resp_val && !empty) e_rv[head] = 1'b1;
        e_mrr = !empty && resp_rdy[head];
        chk("mem_req_val", 128'(mem_req_val), 128'(e_mval));
        if (e_mval) chk("mem_req_msg", 128'(mem_req_msg), 128'(req_msg[g*QW +: QW]));
        chk("req_rdy", 128'(req_rdy), 128'(e_rdy));
        chk("resp_val", 128'(resp_val), 128'(e_rv));
        chk("mem_resp_rdy", 128'(mem_resp_rdy), 128'(e_mrr));
        chk("resp_msg", 128'(resp_msg), 128'({NR{mem_resp_msg}}));
        m_push = e_mval && mem_req_rdy && !reset;
        m_pop  = mem_resp_val && e_mrr && !reset;
        if (m_pop) void'(q.pop_front());
        if (m_push) begin
            q.push_back(g);
            rr = (g + 1) % NR;
        end
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        model_reset();
        check_cycle();
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [NR-1:0] tab_fix [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
    logic [NR-1:0] tab_rr  [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00};
    logic [NR-1:0] c_rdy   [5] = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b11};
    logic [NR-1:0] c_rv    [5] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b01};
    logic          c_mrr   [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    int            c_di    [5] = '{0, 1, 1, 2, 3};
    int            c_src   [4] = '{0, 1, 1, 0};

    initial begin
        int acc;
        logic [NR-1:0] exp_g;
        logic [31:0] d;
        logic [SW-1:0] rmsg;
        logic [QW-1:0] qmsg;
        idle();
        reset = 1'b1;
        model_reset();
        @(negedge clk);

        // Reset state, idle inputs, memory ready
        check_cycle();
        chk("rst mem_req_val", 128'(mem_req_val), 128'(0));
        chk("rst req_rdy", 128'(req_rdy), 128'(0));
        chk("rst resp_val", 128'(resp_val), 128'(0));
        chk("rst mem_resp_rdy", 128'(mem_resp_rdy), 128'(0));
        @(negedge clk);
        reset = 1'b0;

        // Single requester read of 0x100, one-cycle memory latency
        qmsg = mk_req(32'h100, 8'h11);
        req_val = 2'b01;
        req_msg[QW-1:0] = qmsg;
        check_cycle();
        chk("single mem_req_msg", 128'(mem_req_msg), 128'(qmsg));
        chk("single req_rdy", 128'(req_rdy), 128'(2'b01));
        @(negedge clk);
        idle();
        rmsg = {15'h0, 32'hDEADBEEF};
        mem_resp_val = 1'b1;
        mem_resp_msg = rmsg;
        check_cycle();
        chk("single resp_val", 128'(resp_val), 128'(2'b01));
        chk("single resp data", 128'(resp_msg[SW-1:0]), 128'(rmsg));
        chk("single mem_resp_rdy", 128'(mem_resp_rdy), 128'(1));
        @(negedge clk);

        // Both valid, memory never answers: grant order then full stall
        do_reset();
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            idle();
            req_val = 2'b11;
            req_msg = {rand_req(), rand_req()};
            check_cycle();
`ifdef PAGERANK_MEM_ARB_RR_EN
            exp_g = tab_rr[c];
`else
            exp_g = tab_fix[c];
`endif
            chk("grant seq", 128'(req_rdy), 128'(exp_g));
            if (mem_req_val && mem_req_rdy) acc++;
            @(negedge clk);
        end
        chk("accepted when full", 128'(acc), 128'(4));
        mem_resp_val = 1'b1;
        mem_resp_msg = rand_resp();
        check_cycle();
        chk("full pop resp_val", 128'(resp_val), 128'(2'b01));
        chk("full pop req_rdy", 128'(req_rdy), 128'(2'b00));
        @(negedge clk);
        mem_resp_val = 1'b0;
        check_cycle();
        chk("slot freed req_rdy", 128'(req_rdy), 128'(2'b01));
        @(negedge clk);

        // Interleaved 0,1,1,0 with a response-side stall on requester 1
        do_reset();
        for (int c = 0; c < 4; c++) begin
            idle();
            req_val = '0;
            req_val[c_src[c]] = 1'b1;
            req_msg[c_src[c]*QW +: QW] = mk_req(32'(c * 4), 8'(c));
            check_cycle();
            chk("ilv req_rdy", 128'(req_rdy), 128'(req_val));
            @(negedge clk);
        end
        for (int c = 0; c < 5; c++) begin
            idle();
            d = 32'hA000_0000 + 32'(c_di[c]);
            mem_resp_val = 1'b1;
            mem_resp_msg = {15'h0, d};
            resp_rdy = c_rdy[c];
            check_cycle();
            chk("ilv resp_val", 128'(resp_val), 128'(c_rv[c]));
            chk("ilv mem_resp_rdy", 128'(mem_resp_rdy), 128'(c_mrr[c]));
            chk("ilv data r1", 128'(resp_msg[SW +: 32]), 128'(d));
            @(negedge clk);
        end

        // Stray response with nothing outstanding is held
        for (int c = 0; c < 3; c++) begin
            idle();
            mem_resp_val = 1'b1;
            mem_resp_msg = rand_resp();
            check_cycle();
            chk("stray mem_resp_rdy", 128'(mem_resp_rdy), 128'(0));
            chk("stray resp_val", 128'(resp_val), 128'(0));
            @(negedge clk);
        end

        // Async reset with three outstanding requests
        for (int c = 0; c < 3; c++) begin
            idle();
            req_val = 2'b01;
            req_msg = {rand_req(), rand_req()};
            check_cycle();
            @(negedge clk);
        end
        idle();
        mem_resp_val = 1'b1;
        mem_resp_msg = rand_resp();
        #2;
        reset = 1'b1;
        model_reset();
        check_cycle();
        chk("arst resp_val", 128'(resp_val), 128'(0));
        chk("arst mem_resp_rdy", 128'(mem_resp_rdy), 128'(0));
        chk("arst mem_req_val", 128'(mem_req_val), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        req_val = 2'b11;
        req_msg = {rand_req(), rand_req()};
        check_cycle();
        chk("arst rr restart", 128'(req_rdy), 128'(2'b01));
        chk("arst held resp", 128'(resp_val), 128'(0));
        @(negedge clk);
        idle();
        req_val = 2'b10;
        req_msg = {rand_req(), rand_req()};
        check_cycle();
        chk("arst req1 grant", 128'(req_rdy), 128'(2'b10));
        @(negedge clk);

        // Random traffic; bench memory answers in order with random stalls
        do_reset();
        memq.delete();
        for (int c = 0; c < 2000; c++) begin
            req_val     = NR'($urandom);
            req_msg     = {rand_req(), rand_req()};
            mem_req_rdy = ($urandom_range(0, 3) != 0);
            resp_rdy    = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
            if (memq.size() != 0) begin
                mem_resp_val = ($urandom_range(0, 9) < 7);
                mem_resp_msg = memq[0];
            end else begin
                mem_resp_val = ($urandom_range(0, 9) == 0);
                mem_resp_msg = rand_resp();
            end
            check_cycle();
            if (m_pop) void'(memq.pop_front());
            if (m_push) memq.push_back(rand_resp());
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
